// File: rtl/sram_cache_controller_pkg.sv
// rtl/sram_cache_controller_pkg.sv - shared constants, address fields and FSM encoding
package sram_cache_controller_pkg;

    localparam int ADDR_W    = 32;
    localparam int SETS      = 64;
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = 10;

    // Address layout: [2] word in block, [8:3] set index, [18:9] tag
    localparam int WORD_BIT  = 2;
    localparam int BLOCK_LSB = 3;
    localparam int IDX_LSB   = BLOCK_LSB;
    localparam int IDX_MSB   = IDX_LSB + IDX_W - 1;
    localparam int TAG_LSB   = IDX_MSB + 1;
    localparam int TAG_MSB   = TAG_LSB + TAG_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_MISS = 2'd1,
        ST_WRITE     = 2'd2
    } state_t;

    // 64-bit block address used for SRAM block reads
    function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:BLOCK_LSB], {BLOCK_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/sram_cache_controller_if.sv
// rtl/sram_cache_controller_if.sv - MEM-stage load/store bus between pipeline and cache
interface sram_cache_controller_if;
    import sram_cache_controller_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [31:0]       rdata;
    logic              ready;

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN,
        input  rdata, ready
    );

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN,
        output rdata, ready
    );

endinterface

// File: rtl/sram_cache_controller_cache_way_array.sv
// rtl/sram_cache_controller_cache_way_array.sv - 2-way tag/data/valid storage with 1-bit LRU per set
module cache_way_array
    import sram_cache_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    input  logic             word_sel,
    output logic             hit,
    output logic             hit_way,
    output logic [31:0]      hit_word,
    output logic             victim_way,
    input  logic             touch_en,
    input  logic             fill_en,
    input  logic [63:0]      fill_data,
    input  logic             write_en,
    input  logic [31:0]      write_word
);

    logic [1:0]       valid_q [SETS];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];

    logic [1:0]       match;
    logic [63:0]      hit_blk;

    // Tag compare for both ways; way 0 wins if both ever match
    always_comb begin
        match[0]   = valid_q[index][0] && (tag_q[0][index] == tag);
        match[1]   = valid_q[index][1] && (tag_q[1][index] == tag);
        hit        = |match;
        hit_way    = !match[0];
        hit_blk    = data_q[hit_way][index];
        hit_word   = word_sel ? hit_blk[63:32] : hit_blk[31:0];
        victim_way = lru_q[index];
    end

    // Valid and LRU state; cleared asynchronously so the cache is empty out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 2'b00;
            end
            lru_q <= '0;
        end else if (fill_en) begin
            valid_q[index][victim_way] <= 1'b1;
            lru_q[index]               <= ~victim_way;
        end else if ((touch_en || write_en) && hit) begin
            lru_q[index] <= ~hit_way;
        end
    end

    // Tag and data payload; only meaningful behind a valid bit, so no reset needed
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim_way][index]  <= tag;
            data_q[victim_way][index] <= fill_data;
        end else if (write_en && hit) begin
            if (word_sel) begin
                data_q[hit_way][index][63:32] <= write_word;
            end else begin
                data_q[hit_way][index][31:0]  <= write_word;
            end
        end
    end

endmodule

// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - write-through 2-way read cache in front of the SRAM controller
module sram_cache_controller
    import sram_cache_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sram_cache_controller_if.slave mem_bus,
    output logic [ADDR_W-1:0]    sram_address,
    output logic [31:0]          sram_wdata,
    output logic                 sram_read_en,
    output logic                 sram_write_en,
    input  logic [63:0]          sram_rdata,
    input  logic                 sram_ready
);

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             word_sel;

    logic             hit;
    logic             hit_way;
    logic [31:0]      hit_word;
    logic             victim_way;
    logic             touch_en;
    logic             fill_en;
    logic             write_en;

    assign index    = mem_bus.address[IDX_MSB:IDX_LSB];
    assign tag      = mem_bus.address[TAG_MSB:TAG_LSB];
    assign word_sel = mem_bus.address[WORD_BIT];

    cache_way_array u_ways (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .tag        (tag),
        .word_sel   (word_sel),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_word   (hit_word),
        .victim_way (victim_way),
        .touch_en   (touch_en),
        .fill_en    (fill_en),
        .fill_data  (sram_rdata),
        .write_en   (write_en),
        .write_word (mem_bus.wdata)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, SRAM strobes, pipeline ready/rdata and cache update strobes
    always_comb begin
        state_d       = state_q;
        mem_bus.ready = 1'b0;
        mem_bus.rdata = '0;
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
        sram_wdata    = '0;
        sram_address  = block_addr(mem_bus.address);
        touch_en      = 1'b0;
        fill_en       = 1'b0;
        write_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_bus.MEM_W_EN) begin
                    sram_address = mem_bus.address;
                    state_d      = ST_WRITE;
                end else if (mem_bus.MEM_R_EN) begin
                    if (hit) begin
                        mem_bus.ready = 1'b1;
                        mem_bus.rdata = hit_word;
                        touch_en      = 1'b1;
                    end else begin
                        state_d = ST_READ_MISS;
                    end
                end else begin
                    mem_bus.ready = 1'b1;
                end
            end
            ST_READ_MISS: begin
                sram_read_en = 1'b1;
                if (sram_ready) begin
                    mem_bus.ready = 1'b1;
                    mem_bus.rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill_en       = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_WRITE: begin
                sram_address  = mem_bus.address;
                sram_write_en = 1'b1;
                sram_wdata    = mem_bus.wdata;
                if (sram_ready) begin
                    mem_bus.ready = 1'b1;
                    write_en      = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset drops an in-flight SRAM request immediately and presents an idle bus
        if (rst) begin
            state_d       = ST_IDLE;
            mem_bus.ready = 1'b1;
            mem_bus.rdata = '0;
            sram_read_en  = 1'b0;
            sram_write_en = 1'b0;
            sram_wdata    = '0;
            touch_en      = 1'b0;
            fill_en       = 1'b0;
            write_en      = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_cache_controller.sv
// tb/tb_sram_cache_controller.sv - scoreboard bench for sram_cache_controller
module tb_sram_cache_controller;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    sram_cache_controller_if mem_if ();

    sram_cache_controller dut (
        .clk           (clk),
        .rst           (rst),
        .mem_bus       (mem_if),
        .sram_address  (sram_address),
        .sram_wdata    (sram_wdata),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_rdata    (sram_rdata),
        .sram_ready    (sram_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt      = 0;
    logic [31:0] sb_q [$];
    logic [63:0] mem [logic [31:0]];

    function automatic logic [63:0] mem_read(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        if (mem.exists(b)) return mem[b];
        return {b ^ 32'h5EED_0004, b ^ 32'h5EED_0000};
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [63:0] blk;
        blk = mem_read(a);
        return a[2] ? blk[63:32] : blk[31:0];
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] blk;
        blk = mem_read(a);
        if (a[2]) blk[63:32] = d;
        else      blk[31:0]  = d;
        mem[{a[31:3], 3'b000}] = blk;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM controller model: ready pulses after LAT strobed cycles; writes commit on the pulse
    initial begin
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (sram_ready) begin
                sram_ready = 1'b0;
                cnt = 0;
            end else if (sram_read_en || sram_write_en) begin
                cnt++;
                if (cnt == LAT) begin
                    sram_ready = 1'b1;
                    if (sram_write_en) mem_write(sram_address, sram_wdata);
                    sram_rdata = mem_read(sram_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp,
                           input int exp_waits, input string tag);
        int waits = 0;
        int rd_cycles = 0;
        bit done = 0;
        sb_q.push_back(exp);
        @(negedge clk);
        mem_if.address  = a;
        mem_if.wdata    = '0;
        mem_if.MEM_R_EN = 1'b1;
        mem_if.MEM_W_EN = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #4;
            if (sram_read_en) begin
                rd_cycles++;
                if (rd_cycles == 1) check_eq({tag, " sram_address"}, 64'(sram_address), 64'({a[31:3], 3'b000}));
            end
            if (mem_if.ready) done = 1;
            else begin
                waits++;
                @(negedge clk);
            end
        end
        check_eq({tag, " done"}, 64'(done), 64'(1));
        if (done) check_eq({tag, " rdata"}, 64'(mem_if.rdata), 64'(sb_q.pop_front()));
        else void'(sb_q.pop_front());
        check_eq({tag, " wait cycles"}, 64'(waits), 64'(exp_waits));
        check_eq({tag, " read strobe cycles"}, 64'(rd_cycles), 64'(exp_waits));
        @(negedge clk);
        mem_if.MEM_R_EN = 1'b0;
        mem_if.MEM_W_EN = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic also_read, input string tag);
        int waits = 0;
        int wr_cycles = 0;
        int rd_cycles = 0;
        bit done = 0;
        @(negedge clk);
        mem_if.address  = a;
        mem_if.wdata    = d;
        mem_if.MEM_R_EN = also_read;
        mem_if.MEM_W_EN = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            #4;
            if (sram_read_en) rd_cycles++;
            if (sram_write_en) begin
                wr_cycles++;
                if (wr_cycles == 1) begin
                    check_eq({tag, " sram_wdata"}, 64'(sram_wdata), 64'(d));
                    check_eq({tag, " sram_address"}, 64'(sram_address), 64'(a));
                end
            end
            if (mem_if.ready) done = 1;
            else begin
                waits++;
                @(negedge clk);
            end
        end
        check_eq({tag, " done"}, 64'(done), 64'(1));
        check_eq({tag, " wait cycles"}, 64'(waits), 64'(LAT));
        check_eq({tag, " write strobe cycles"}, 64'(wr_cycles), 64'(LAT));
        check_eq({tag, " read strobe cycles"}, 64'(rd_cycles), 64'(0));
        @(negedge clk);
        mem_if.MEM_R_EN = 1'b0;
        mem_if.MEM_W_EN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        mem_if.address  = 32'h0000_0400;
        mem_if.wdata    = '0;
        mem_if.MEM_R_EN = 1'b1;
        mem_if.MEM_W_EN = 1'b0;
        mem[32'h0000_0400] = {32'hBBBB_BBBB, 32'hAAAA_AAAA};

        repeat (2) @(negedge clk);
        #4;
        check_eq("reset ready", 64'(mem_if.ready), 64'(1));
        check_eq("reset rdata", 64'(mem_if.rdata), 64'(0));
        check_eq("reset read_en", 64'(sram_read_en), 64'(0));
        check_eq("reset write_en", 64'(sram_write_en), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        mem_if.MEM_R_EN = 1'b0;
        #4;
        check_eq("idle ready", 64'(mem_if.ready), 64'(1));
        check_eq("idle rdata", 64'(mem_if.rdata), 64'(0));

        do_read(32'h0000_0400, 32'hAAAA_AAAA, LAT, "cold 400");
        do_read(32'h0000_0404, 32'hBBBB_BBBB, 0, "hit 404");
        do_write(32'h0000_0404, 32'h1234_5678, 1'b0, "store 404");
        do_read(32'h0000_0404, 32'h1234_5678, 0, "hit 404 after store");
        do_read(32'h0000_0400, 32'hAAAA_AAAA, 0, "hit 400 other word");
        do_write(32'h0000_0800, 32'hDEAD_BEEF, 1'b0, "store 800 uncached");
        do_read(32'h0000_0800, 32'hDEAD_BEEF, LAT, "miss 800 no-alloc");
        do_write(32'h0000_0404, 32'hCAFE_F00D, 1'b1, "both enables");
        do_read(32'h0000_0404, 32'hCAFE_F00D, 0, "hit 404 after both");

        // reset in the middle of a read miss
        @(negedge clk);
        mem_if.address  = 32'h0000_1000;
        mem_if.MEM_R_EN = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check_eq("mid-miss read_en", 64'(sram_read_en), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst mid-miss read_en", 64'(sram_read_en), 64'(0));
        check_eq("rst mid-miss ready", 64'(mem_if.ready), 64'(1));
        check_eq("rst mid-miss rdata", 64'(mem_if.rdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        mem_if.MEM_R_EN = 1'b0;
        #4;
        check_eq("post-rst idle ready", 64'(mem_if.ready), 64'(1));
        check_eq("post-rst idle read_en", 64'(sram_read_en), 64'(0));
        do_read(32'h0000_0404, 32'hCAFE_F00D, LAT, "miss 404 after rst");

        // LRU replacement in set 0 on a clean cache
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h0000_0200, word_of(32'h0000_0200), LAT, "lru fill 200");
        do_read(32'h0000_0400, 32'hAAAA_AAAA, LAT, "lru fill 400");
        do_read(32'h0000_0600, word_of(32'h0000_0600), LAT, "lru fill 600");
        do_read(32'h0000_0400, 32'hAAAA_AAAA, 0, "lru hit 400");
        do_read(32'h0000_0200, word_of(32'h0000_0200), LAT, "lru evicted 200");
        do_read(32'h0000_0400, 32'hAAAA_AAAA, 0, "lru hit 400 again");

        check_eq("scoreboard empty", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
